// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: the BRAM read port on one side and the
// outgoing valid/ready word stream on the other. The master modport is the
// sequencer's view; the slave modport is the view of whoever owns the BRAM
// and consumes the stream.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output bram_we, bram_addr, m_data, m_valid,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_we, bram_addr, m_data, m_valid,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a single-port READ_FIRST BRAM. Streams `length`
// consecutive words starting at `base_addr` (address wraps modulo depth)
// through a 2-entry output buffer, absorbing the BRAM's 1-cycle read latency.
// A read is only issued when the buffer is guaranteed room for its data, so
// backpressure never drops or duplicates a word.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  bram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  inflight_r;
  logic [1:0]            count_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  pop_s;
  logic                  push_s;
  logic [2:0]            occ_s;
  logic                  issue_s;
  logic                  last_s;

  // Handshake, occupancy look-ahead, read-issue and completion decisions.
  always_comb begin
    pop_s   = (count_r != 2'd0) && bus.m_ready;
    push_s  = inflight_r;
    // Occupancy the buffer will hold once the current pop and in-flight word settle.
    occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s = (state_r == RUN) && (remaining_r != {(ADDR_WIDTH+1){1'b0}}) && (occ_s < 3'd2);
    // Finish on the edge of the final handshake so done lands in the next cycle.
    if ((remaining_r == {(ADDR_WIDTH+1){1'b0}}) && !inflight_r) begin
      last_s = (count_r == 2'd0) || ((count_r == 2'd1) && pop_s);
    end else begin
      last_s = 1'b0;
    end
  end

  // Sequencer state, address/count tracking and the 2-entry output buffer.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_r     <= IDLE;
      remaining_r <= {(ADDR_WIDTH+1){1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      inflight_r  <= 1'b0;
      count_r     <= 2'd0;
      buf0_r      <= {DATA_WIDTH{1'b0}};
      buf1_r      <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      // buf0_r is always the head word, so m_data stays put while stalled.
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            buf0_r <= bus.bram_dout;
          end else begin
            buf1_r <= bus.bram_dout;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          buf0_r  <= buf1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            buf0_r <= buf1_r;
            buf1_r <= bus.bram_dout;
          end else begin
            buf0_r <= bus.bram_dout;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase

      inflight_r <= issue_s;
      if (issue_s) begin
        addr_r      <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        remaining_r <= remaining_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
      end

      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (length == {(ADDR_WIDTH+1){1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= RUN;
              busy_r      <= 1'b1;
              addr_r      <= base_addr;
              remaining_r <= length;
            end
          end
        end
        RUN: begin
          if (last_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_addr = addr_r;
  assign bus.m_data    = buf0_r;
  assign bus.m_valid   = (count_r != 2'd0);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural READ_FIRST BRAM, a scoreboard
// filled from mem[(base+i) mod depth] when a transfer is launched, and a
// negedge monitor that pops and compares on every handshake.
module tb_bram_stream_reader;
  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          rsta_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;

  bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clka = ~clka;

  logic [DW-1:0] mem [DEPTH];

  // READ_FIRST single-port BRAM: output registered one cycle after the address.
  always @(posedge clka) begin
    bus.bram_dout <= mem[bus.bram_addr];
  end

  longint cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // 0: always ready, 1: pattern 1,0,0,1, 2: random, 3: never ready
  int ready_mode = 0;
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clka);
      #1;
      case (ready_mode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  logic [DW-1:0] exp_q [$];
  longint first_valid_cyc = -1;
  longint last_pop_cyc = -1;
  longint done_cyc = -1;
  int     done_cnt = 0;
  bit     busy_seen = 0;
  bit     prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clka);
      if (!rsta_n) begin
        prev_stall = 0;
      end else begin
        chk("bram_we_zero", longint'(bus.bram_we), 0);
        if (prev_stall) begin
          chk("stall_valid_hold", longint'(bus.m_valid), 1);
          chk("stall_data_hold", longint'(bus.m_data), longint'(prev_data));
        end
        if (bus.m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (busy === 1'b1) busy_seen = 1;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", longint'(bus.m_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", longint'(bus.m_data), longint'(e));
          end
          last_pop_cyc = cyc;
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
        prev_data  = bus.m_data;
      end
    end
  end

  task automatic run_xfer(input int b, input int len, input int mode);
    longint s;
    logic [AW-1:0] addr_before;
    int bound;
    ready_mode = mode;
    @(posedge clka);
    #1;
    first_valid_cyc = -1;
    last_pop_cyc = -1;
    done_cnt = 0;
    busy_seen = 0;
    addr_before = bus.bram_addr;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW+1)'(len);
    s = cyc;
    @(posedge clka);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    length = (AW+1)'($urandom);
    bound = len * 8 + 20;
    for (int k = 0; k < bound && done_cnt == 0; k++) @(posedge clka);
    chk("done_seen", longint'(done_cnt != 0), 1);
    repeat (3) @(posedge clka);
    chk("done_once", done_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    if (len > 0) begin
      chk("done_after_last_beat", done_cyc, last_pop_cyc + 1);
      chk("busy_seen", longint'(busy_seen), 1);
      if (mode == 0) begin
        chk("first_valid_latency", first_valid_cyc, s + 3);
        chk("no_bubbles", last_pop_cyc - first_valid_cyc, len - 1);
      end
    end else begin
      chk("len0_done_time", done_cyc, s + 1);
      chk("len0_no_valid", first_valid_cyc, -1);
      chk("len0_busy_low", longint'(busy_seen), 0);
      chk("len0_addr_kept", longint'(bus.bram_addr), longint'(addr_before));
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k + 16'h0100);
    rsta_n = 1'b0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_m_valid", longint'(bus.m_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_bram_addr", longint'(bus.bram_addr), 0);
    chk("rst_bram_we", longint'(bus.bram_we), 0);
    @(posedge clka);
    #1;
    rsta_n = 1'b1;

    run_xfer(4, 8, 0);      // basic stream, latency and throughput
    run_xfer(4, 8, 1);      // 1,0,0,1 backpressure
    run_xfer(510, 4, 2);    // address wrap
    run_xfer(37, 0, 0);     // zero length
    run_xfer(0, 512, 0);    // full depth, no bubbles

    // Reset in the middle of a stalled transfer with a full buffer.
    ready_mode = 3;
    @(posedge clka);
    #1;
    start = 1'b1;
    base_addr = AW'(100);
    length = (AW+1)'(8);
    @(posedge clka);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clka);
    #1;
    rsta_n = 1'b0;
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    @(negedge clka);
    chk("midrst_m_valid", longint'(bus.m_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    exp_q.delete();
    run_xfer(0, 2, 0);

    // Randomized transfers over random memory contents.
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
    for (int t = 0; t < 10; t++) begin
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
